// File: rtl/adder_seq_ctrl.sv
// adder_seq_ctrl: WIDTH-bit adder built from one 2-bit ripple slice reused
// over WIDTH/2 cycles, least significant slice first. Operands arrive and
// results leave over valid/ready handshakes.
module adder_seq_ctrl #(
    parameter int WIDTH = 8   // must be even and >= 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int N  = WIDTH / 2;
    localparam int KW = (N > 1) ? $clog2(N) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] sum_q;
    logic             c_q;
    logic [KW-1:0]    k_q;
    logic             out_valid_q;
    logic             busy_q;

    // Bit offset of the active slice (2*k).
    logic [KW:0]      shamt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [2:0]       slice_d;
    logic [WIDTH-1:0] sum_d;

    // One 2-bit ripple slice: {carry, sum[1:0]} = x + y + c.
    function automatic logic [2:0] slice_add(input logic [1:0] x,
                                             input logic [1:0] y,
                                             input logic       c);
        return {1'b0, x} + {1'b0, y} + {2'b00, c};
    endfunction

    // Select the active slice of the operands and merge its result into the
    // running sum. sum_q is cleared on load, so OR-ing in the slice is enough.
    always_comb begin
        shamt   = {k_q, 1'b0};
        a_sh    = a_q >> shamt;
        b_sh    = b_q >> shamt;
        slice_d = slice_add(a_sh[1:0], b_sh[1:0], c_q);
        sum_d   = sum_q | (WIDTH'(slice_d[1:0]) << shamt);
    end

    // Operand capture on the input handshake; no reset needed for pure data.
    always_ff @(posedge clk) begin
        if (in_valid && in_ready) begin
            a_q <= a;
            b_q <= b;
        end
    end

    // Control FSM with registered outputs; carry and result are reset so that
    // sum/cout read as zero after an aborted operation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            sum_q       <= '0;
            c_q         <= 1'b0;
            k_q         <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        c_q     <= cin;
                        k_q     <= '0;
                        sum_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= S_RUN;
                    end
                end
                S_RUN: begin
                    sum_q <= sum_d;
                    c_q   <= slice_d[2];
                    if (k_q == K_LAST) begin
                        out_valid_q <= 1'b1;
                        state_q     <= S_DONE;
                    end else begin
                        k_q <= k_q + 1'b1;
                    end
                end
                S_DONE: begin
                    // Result and carry hold until the consumer takes them.
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // in_ready is a pure decode of state and reset, independent of in_valid.
    assign in_ready  = (state_q == S_IDLE) && !rst;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign sum       = sum_q;
    assign cout      = c_q;

endmodule

// File: tb/tb_adder_seq_ctrl.sv
// Bench for adder_seq_ctrl: WIDTH=8 instance checked every cycle against a
// cycle-count reference model, plus a WIDTH=2 instance with direct checks.
module tb_adder_seq_ctrl;

    localparam int N = 4;   // slices of the WIDTH=8 instance

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // WIDTH=8 instance
    logic       in_valid = 1'b0, out_ready = 1'b0, cin = 1'b0;
    logic [7:0] a = '0, b = '0;
    logic       in_ready, out_valid, cout, busy;
    logic [7:0] sum;

    adder_seq_ctrl #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .busy(busy)
    );

    // WIDTH=2 instance
    logic       in_valid2 = 1'b0, out_ready2 = 1'b0, cin2 = 1'b0;
    logic [1:0] a2 = '0, b2 = '0;
    logic       in_ready2, out_valid2, cout2, busy2;
    logic [1:0] sum2;

    adder_seq_ctrl #(.WIDTH(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2),
        .a(a2), .b(b2), .cin(cin2), .out_valid(out_valid2), .out_ready(out_ready2),
        .sum(sum2), .cout(cout2), .busy(busy2)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: an accepted operation occupies the block for N cycles,
    // then the result a+b+cin waits until out_ready is seen high.
    int         cyc = 0;
    int         m_left = 0;
    bit         m_have = 1'b0;
    logic [8:0] m_res = '0;
    int         m_acc_cnt = 0;
    int         m_acc_cyc = 0;

    function automatic bit m_idle();
        return !m_have && (m_left == 0);
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_left = 0;
            m_have = 1'b0;
        end else begin
            cyc++;
            if (m_have) begin
                if (out_ready) m_have = 1'b0;
            end else if (m_left > 0) begin
                m_left--;
                if (m_left == 0) m_have = 1'b1;
            end else if (in_valid) begin
                m_left    = N;
                m_res     = 9'(a) + 9'(b) + 9'(cin);
                m_acc_cnt++;
                m_acc_cyc = cyc;
            end
        end
    end

    // Every-cycle comparison against the model, mid-cycle.
    always @(negedge clk) begin
        chk("in_ready", 32'(in_ready), 32'(m_idle() && !rst));
        chk("busy", 32'(busy), 32'(!m_idle()));
        chk("out_valid", 32'(out_valid), 32'(m_have));
        if (m_have) begin
            chk("sum", 32'(sum), 32'(m_res[7:0]));
            chk("cout", 32'(cout), 32'(m_res[8]));
        end
        if (rst) begin
            chk("rst_sum", 32'(sum), 32'd0);
            chk("rst_cout", 32'(cout), 32'd0);
        end
    end

    // Returns at posedge+2 once a new accept is seen by the model.
    task automatic wait_accept(input int prev, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #2;
            if (m_acc_cnt != prev) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Returns at the first negedge with out_valid high.
    task automatic wait_out(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // One operation with out_ready high; pins latency and result to literals.
    task automatic op8(input logic [7:0] ta, input logic [7:0] tb_v, input logic tc,
                       input logic [8:0] exp, input string nm);
        int prev;
        bit ok;
        prev      = m_acc_cnt;
        a         = ta;
        b         = tb_v;
        cin       = tc;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        wait_accept(prev, ok);
        chk({nm, "_accept"}, 32'(ok), 32'd1);
        in_valid = 1'b0;
        wait_out(ok);
        chk({nm, "_outwait"}, 32'(ok), 32'd1);
        chk({nm, "_latency"}, 32'(cyc - m_acc_cyc), 32'(N));
        chk({nm, "_sum"}, 32'(sum), 32'(exp[7:0]));
        chk({nm, "_cout"}, 32'(cout), 32'(exp[8]));
        @(posedge clk);
        #2;
        out_ready = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int   prev;
        bit   ok;
        int   ed;
        int   acc[3];
        logic [7:0] ba[3];
        logic [7:0] bb[3];
        logic       bc[3];
        logic [2:0] e2;

        // Reset state
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset_in_ready", 32'(in_ready), 32'd0);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_in_ready2", 32'(in_ready2), 32'd0);
        @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        chk("post_reset_in_ready", 32'(in_ready), 32'd1);
        chk("post_reset_in_ready2", 32'(in_ready2), 32'd1);
        @(posedge clk);
        #2;

        // Directed operations with literal results
        op8(8'h5A, 8'h3C, 1'b0, 9'h096, "t_5a_3c");
        op8(8'hFF, 8'h01, 1'b0, 9'h100, "t_ripple");
        op8(8'hFF, 8'hFF, 1'b1, 9'h1FF, "t_allones");

        // Backpressure with a new operand offered throughout
        prev      = m_acc_cnt;
        a         = 8'h12;
        b         = 8'h34;
        cin       = 1'b1;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        wait_accept(prev, ok);
        chk("bp_accept", 32'(ok), 32'd1);
        a   = 8'h77;
        b   = 8'h11;
        cin = 1'b0;
        prev = m_acc_cnt;
        wait_out(ok);
        chk("bp_outwait", 32'(ok), 32'd1);
        for (int i = 0; i < 6; i++) begin
            chk("bp_hold_sum", 32'(sum), 32'h47);
            chk("bp_hold_cout", 32'(cout), 32'd0);
            chk("bp_hold_in_ready", 32'(in_ready), 32'd0);
            @(negedge clk);
        end
        chk("bp_no_accept", 32'(m_acc_cnt), 32'(prev));
        @(posedge clk);
        #2 out_ready = 1'b1;
        @(posedge clk);
        #1 ed = cyc;
        #1 out_ready = 1'b0;
        wait_accept(prev, ok);
        chk("bp_new_accept", 32'(ok), 32'd1);
        chk("bp_accept_cycle", 32'(m_acc_cyc), 32'(ed + 1));
        in_valid = 1'b0;
        wait_out(ok);
        chk("bp_second_sum", 32'(sum), 32'h88);
        chk("bp_second_cout", 32'(cout), 32'd0);
        @(posedge clk);
        #2 out_ready = 1'b1;
        @(posedge clk);
        #2 out_ready = 1'b0;

        // Reset in the middle of RUN, after two slices
        prev     = m_acc_cnt;
        a        = 8'hAA;
        b        = 8'h55;
        cin      = 1'b0;
        in_valid = 1'b1;
        wait_accept(prev, ok);
        chk("rr_accept", 32'(ok), 32'd1);
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        chk("rr_out_valid", 32'(out_valid), 32'd0);
        chk("rr_busy", 32'(busy), 32'd0);
        chk("rr_sum", 32'(sum), 32'd0);
        @(posedge clk);
        #2 rst = 1'b0;
        op8(8'h01, 8'h01, 1'b0, 9'h002, "t_after_reset");

        // Back-to-back with in_valid and out_ready held high
        ba = '{8'h12, 8'h80, 8'hC3};
        bb = '{8'h34, 8'h80, 8'h3D};
        bc = '{1'b0, 1'b1, 1'b0};
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            a    = ba[i];
            b    = bb[i];
            cin  = bc[i];
            prev = m_acc_cnt;
            wait_accept(prev, ok);
            chk("b2b_accept", 32'(ok), 32'd1);
            acc[i] = m_acc_cyc;
        end
        in_valid = 1'b0;
        chk("b2b_gap1", 32'(acc[1] - acc[0]), 32'd6);
        chk("b2b_gap2", 32'(acc[2] - acc[1]), 32'd6);
        repeat (N + 3) @(posedge clk);
        #2 out_ready = 1'b0;

        // WIDTH=2: one slice, result one cycle after accept
        out_ready2 = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if (i == 0) begin
                a2 = 2'd3; b2 = 2'd3; cin2 = 1'b1;
            end else begin
                a2 = 2'($urandom); b2 = 2'($urandom); cin2 = 1'($urandom);
            end
            e2 = {1'b0, a2} + {1'b0, b2} + {2'b00, cin2};
            if (i == 0) chk("w2_literal_model", 32'(e2), 32'h7);
            in_valid2 = 1'b1;
            @(negedge clk);
            chk("w2_in_ready", 32'(in_ready2), 32'd1);
            @(posedge clk);
            #2 in_valid2 = 1'b0;
            @(negedge clk);
            chk("w2_busy_run", 32'(busy2), 32'd1);
            chk("w2_out_valid_run", 32'(out_valid2), 32'd0);
            @(negedge clk);
            chk("w2_out_valid", 32'(out_valid2), 32'd1);
            chk("w2_sum", 32'(sum2), 32'(e2[1:0]));
            chk("w2_cout", 32'(cout2), 32'(e2[2]));
            @(posedge clk);
            #2;
        end
        out_ready2 = 1'b0;

        // Random traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk);
            #2;
            rst       = ($urandom_range(0, 299) == 0);
            in_valid  = ($urandom_range(0, 2) != 0);
            out_ready = 1'($urandom);
            a         = 8'($urandom);
            b         = 8'($urandom);
            cin       = 1'($urandom);
        end
        @(posedge clk);
        #2;
        rst       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (N + 4) @(posedge clk);
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
